decoder_3_8_pulse: RTL and testbench
====================================

# decoder_3_8_pulse

Sequenced 3-to-8 decoder, the inverse of the team's 8-to-3 encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line on `Y` for a fixed number of cycles, followed by a guard gap. It sits on the receive side of one-hot select links, for example strobe and row-select lines, where the far end needs a stable, stretched select pulse rather than a combinational decode.

## Interface
Parameters:
- `PULSE_LEN`, default 4: cycles `Y` is held one-hot per code. Legal range 1..255.
- `GAP_LEN`, default 1: cycles `Y` is held all-zero after each pulse. Legal range 0..255.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `en` input 1: acceptance enable.
- `in_valid` input 1: `A` carries a code.
- `in_ready` output 1: block can accept a code.
- `A` input 3: binary code, 0..7.
- `Y` output 8: registered one-hot output, `Y[A] = 1`.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse when a code's sequence completes.

## Operation
- The FSM has three states: IDLE, DRIVE and GAP. There is one down-counter, 8 bits wide, shared by DRIVE and GAP.
- `in_ready = en && (state == IDLE)`. This is combinational from registered state and `en`.
- **Accept:** occurs when `in_valid && in_ready` is high at a clock edge.
  - Next state is DRIVE.
  - `Y` loads `8'b1 << A`.
  - The counter loads `PULSE_LEN-1`.
- **DRIVE:**
  - Each edge with counter != 0 decrements the counter and holds `Y`.
  - At counter == 0:
    - `Y` is set to 0.
    - If `GAP_LEN == 0`, go to IDLE with `done = 1`.
    - Otherwise, go to GAP with the counter loaded to `GAP_LEN-1`.
- **GAP:**
  - `Y` stays 0.
  - At counter == 0, go to IDLE with `done = 1`. Otherwise decrement.
- All 8 codes are legal. Code 7 drives `Y = 8'h80`, so the decoder is an exact inverse for every one-hot encoder input.
- `en` only gates acceptance. Dropping `en` during DRIVE or GAP does not shorten the sequence.
- `A` is sampled only at the accept edge. Changes to `A` afterwards are ignored.
- At most one bit of `Y` is ever high.

## Timing
- **Reset values:** state IDLE, `Y = 8'h00`, `busy = 0`, `done = 0`, counter = 0. `in_ready` follows `en` from the first cycle after reset.
- **Reset mid-sequence:** `rst` wins over every other condition at that edge.
  - `Y` clears and the state returns to IDLE.
  - No `done` pulse is generated.
  - `in_valid` is not accepted at an edge where `rst` is high.
- **Latency:** `Y` goes one-hot in the cycle after the accept edge.
- **Pulse width:** `Y` stays one-hot for exactly `PULSE_LEN` cycles.
- **Completion:** `done` is high for exactly one cycle, the first IDLE cycle. That cycle is `PULSE_LEN + GAP_LEN + 1` cycles after the accept edge.
- **Throughput:** `in_ready` reasserts in the same cycle as `done`. The back-to-back period is `PULSE_LEN + GAP_LEN + 1` cycles per code.
- **Outputs:** `Y`, `busy` and `done` are registered outputs with no combinational path from inputs. `in_ready` depends combinationally on `en`.

## Configuration
Macro: `DECODER_3_8_STRETCH_EN`.
- **Defined:** behaviour is exactly as above.
- **Undefined:**
  - The DRIVE counter is removed and `PULSE_LEN` is ignored (treated as 1).
  - `Y` is one-hot for a single cycle.
  - GAP behaviour is unchanged, so the period is `GAP_LEN + 2` cycles.

## Structure
- Package `decoder_pkg` holds:
  - the `dec_state_t` enum (IDLE, DRIVE, GAP);
  - the `CNT_W = 8` constant;
  - the `dec3to8` function (code to one-hot).
- One combinational sub-module, `dec38_core`, performs the pure 3-to-8 decode. It wraps `dec3to8` and is reusable by other blocks.
- The top holds the FSM, the counter, the output register and the handshake.

## Test plan
- **Single code:** reset; apply `en = 1` and `A = 3'd5` with a one-cycle `in_valid`. Expect:
  - `Y = 8'h20` for 4 cycles, then `Y = 0` for 1 cycle;
  - `done` high in cycle 6 after the accept edge;
  - `in_ready` low from cycle 1 through cycle 5.
- **Exhaustive inverse:** stream codes 0..7 back-to-back with `in_valid` held high. Expect:
  - `Y = 8'h01, 02, 04, ..., 80` in order;
  - each code accepted every 6 cycles;
  - `$onehot0(Y)` true in every cycle.
- **Gating:** `en = 0` with `in_valid = 1` and `A = 3` for 10 cycles. Expect `in_ready = 0` and `Y = 0` throughout.
  - Then raise `en`: the code is accepted on the first edge and `Y = 8'h08` in the next cycle.
- **Reset mid-pulse:** accept `A = 7`, then assert `rst` in the 2nd DRIVE cycle. Expect:
  - `Y = 0` and `busy = 0` on the next cycle;
  - no `done` pulse;
  - a new code is accepted immediately after `rst` falls.
- **Parameter corners:** `PULSE_LEN = 1, GAP_LEN = 0`. Expect `Y` one-hot for 1 cycle, `done` in the next cycle, period 2.
  - Repeat with `DECODER_3_8_STRETCH_EN` undefined and `PULSE_LEN = 4`. Expect `Y` high for 1 cycle only.
- **Input stability:** change `A` every cycle during DRIVE. Expect `Y` to hold the value captured at the accept edge.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 decoder.
package decoder_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

  function automatic logic [7:0] dec3to8(input logic [2:0] code);
    dec3to8 = 8'h01 << code;
  endfunction

endpackage

// File: rtl/dec38_core.sv
// Pure combinational 3-to-8 one-hot decode, reusable outside the sequencer.
module dec38_core
  import decoder_pkg::*;
(
  input  logic [2:0] code,
  output logic [7:0] onehot
);

  assign onehot = dec3to8(code);

endmodule

// File: rtl/decoder_3_8_pulse.sv
// Sequenced 3-to-8 decoder: one-hot pulse of PULSE_LEN cycles, then GAP_LEN idle cycles.
// Pulse stretching is enabled by defining DECODER_3_8_STRETCH_EN; otherwise the pulse is one cycle.
module decoder_3_8_pulse
  import decoder_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 32'd4,
  parameter int unsigned GAP_LEN   = 32'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] A,
  output logic [7:0] Y,
  output logic       busy,
  output logic       done
);

`ifdef DECODER_3_8_STRETCH_EN
  localparam int unsigned EFF_PULSE = PULSE_LEN;
`else
  // Without stretching the pulse is always a single cycle, whatever PULSE_LEN says.
  localparam int unsigned EFF_PULSE = (PULSE_LEN != 32'd0) ? 32'd1 : 32'd1;
`endif

  localparam bit HAS_GAP = (GAP_LEN != 32'd0);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(EFF_PULSE - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = HAS_GAP ? CNT_W'(GAP_LEN - 32'd1) : CNT_ZERO;

  dec_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [7:0]       y_r, y_nxt_s;
  logic             done_r, done_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic [7:0]       code_onehot_s;
  logic             accept_s;
  logic             cnt_zero_s;

  dec38_core u_core (
    .code   (A),
    .onehot (code_onehot_s)
  );

  assign in_ready   = en && (state_r == IDLE);
  assign accept_s   = in_valid && in_ready;
  assign cnt_zero_s = (cnt_r == CNT_ZERO);

  // State, counter and output registers; rst overrides everything at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      y_r     <= 8'h00;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      y_r     <= y_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Next-state and shared down-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = DRIVE;
          cnt_nxt_s   = DRIVE_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      DRIVE: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (HAS_GAP) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = GAP_LOAD;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      GAP: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    y_nxt_s    = y_r;
    done_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          y_nxt_s = code_onehot_s;
        end else begin
          y_nxt_s = 8'h00;
        end
      end
      DRIVE: begin
        if (!cnt_zero_s) begin
          y_nxt_s = y_r;
        end else begin
          y_nxt_s    = 8'h00;
          done_nxt_s = !HAS_GAP;
        end
      end
      GAP: begin
        y_nxt_s    = 8'h00;
        done_nxt_s = cnt_zero_s;
      end
      default: begin
        y_nxt_s    = 8'h00;
        done_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  assign Y    = y_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_decoder_3_8_pulse.sv
// Directed, table-driven bench for decoder_3_8_pulse (default and PULSE_LEN=1/GAP_LEN=0 instances).
module tb_decoder_3_8_pulse;

`ifdef DECODER_3_8_STRETCH_EN
  localparam int EP = 4;
`else
  localparam int EP = 1;
`endif
  localparam int GL = 1;
  localparam int P  = EP + GL + 1;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, in_ready, busy, done;
  logic [2:0] A;
  logic [7:0] Y;
  logic       en2, valid2, ready2, busy2, done2;
  logic [2:0] a2;
  logic [7:0] y2;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] exp_y;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  decoder_3_8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .Y(Y), .busy(busy), .done(done)
  );

  decoder_3_8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .in_valid(valid2), .in_ready(ready2),
    .A(a2), .Y(y2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("onehot0_y", {31'd0, $onehot0(Y)}, 32'd1);
    check("onehot0_y2", {31'd0, $onehot0(y2)}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int cyc;
    tbl[0] = '{3'd0, 8'h01}; tbl[1] = '{3'd1, 8'h02};
    tbl[2] = '{3'd2, 8'h04}; tbl[3] = '{3'd3, 8'h08};
    tbl[4] = '{3'd4, 8'h10}; tbl[5] = '{3'd5, 8'h20};
    tbl[6] = '{3'd6, 8'h40}; tbl[7] = '{3'd7, 8'h80};

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; A = 3'd0;
    en2 = 1'b1; valid2 = 1'b0; a2 = 3'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_y", {24'd0, Y}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready_en0", {31'd0, in_ready}, 32'd0);
    en = 1'b1; #1;
    check("rst_ready_en1", {31'd0, in_ready}, 32'd1);

    // Single code A=5
    A = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= P; k++) begin
      check("single_y", {24'd0, Y}, (k <= EP) ? 32'h20 : 32'h0);
      check("single_done", {31'd0, done}, (k == P) ? 32'd1 : 32'd0);
      check("single_ready", {31'd0, in_ready}, (k < P) ? 32'd0 : 32'd1);
      check("single_busy", {31'd0, busy}, (k < P) ? 32'd1 : 32'd0);
      tick();
    end
    check("single_done_once", {31'd0, done}, 32'd0);

    // Exhaustive inverse, back-to-back, with A scrambled during the sequence
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      A = tbl[i].a;
      check("inv_ready", {31'd0, in_ready}, 32'd1);
      tick();
      cyc = 1;
      check("inv_y", {24'd0, Y}, {24'd0, tbl[i].exp_y});
      while (in_ready !== 1'b1 && cyc < 20) begin
        A = ~tbl[i].a;
        tick();
        cyc++;
        if (cyc <= EP) check("hold_y", {24'd0, Y}, {24'd0, tbl[i].exp_y});
      end
      check("inv_period", cyc, P);
      check("inv_done", {31'd0, done}, 32'd1);
    end
    in_valid = 1'b0;
    tick();

    // Gating with en low
    en = 1'b0; in_valid = 1'b1; A = 3'd3;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("gate_ready", {31'd0, in_ready}, 32'd0);
      check("gate_y", {24'd0, Y}, 32'd0);
    end
    en = 1'b1; #1;
    check("gate_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("gate_y_accept", {24'd0, Y}, 32'h08);
    wait_done("gate_done");
    tick();

    // Reset mid-pulse, with a code offered during the reset edge
    A = 3'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rstmid_y1", {24'd0, Y}, 32'h80);
    tick();
    rst = 1'b1; in_valid = 1'b1; A = 3'd2;
    tick();
    check("rstmid_y", {24'd0, Y}, 32'd0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_done", {31'd0, done}, 32'd0);
    rst = 1'b0; #1;
    check("rstmid_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("rstmid_new_y", {24'd0, Y}, 32'h04);
    check("rstmid_no_done", {31'd0, done}, 32'd0);
    wait_done("rstmid_new_done");
    tick();

    // PULSE_LEN=1, GAP_LEN=0 instance: period 2
    a2 = 3'd6; valid2 = 1'b1;
    tick();
    a2 = 3'd1;
    check("c1_y", {24'd0, y2}, 32'h40);
    check("c1_done", {31'd0, done2}, 32'd0);
    check("c1_ready", {31'd0, ready2}, 32'd0);
    tick();
    check("c2_y", {24'd0, y2}, 32'd0);
    check("c2_done", {31'd0, done2}, 32'd1);
    check("c2_busy", {31'd0, busy2}, 32'd0);
    check("c2_ready", {31'd0, ready2}, 32'd1);
    tick();
    valid2 = 1'b0;
    check("c3_y", {24'd0, y2}, 32'h02);
    tick();
    check("c4_done", {31'd0, done2}, 32'd1);
    tick();
    check("c5_idle_y", {24'd0, y2}, 32'd0);
    check("c5_idle_done", {31'd0, done2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
